// File: rtl/mac_acc_pipe.sv
// mac_acc_pipe: three-stage pipelined unsigned multiply-accumulate with
// frame-length accumulation, a synchronous clear that travels with its
// sample, and wrap or saturate overflow handling with a sticky flag.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   a, b, cin valid this cycle
//   a, b       unsigned operands (WIDTH bits)
//   cin        carry-in added along with a*b
//   clear      synchronous accumulator clear, pipelined with its cycle
//   acc_len    samples per frame, 0 = free-running; latched at frame start
//   result     accumulator value (ACC_WIDTH bits)
//   out_valid  one-cycle pulse while result holds a completed frame total
//   cout       sticky overflow flag for the current frame
//   count      samples accumulated in the current frame
module mac_acc_pipe #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ACC_WIDTH = 8,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cin,
  input  logic                 clear,
  input  logic [LEN_WIDTH-1:0] acc_len,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 out_valid,
  output logic                 cout,
  output logic [LEN_WIDTH-1:0] count
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = ACC_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Stage 1: operand capture; operands are zeroed when not valid so
  // nothing undefined can reach the multiplier.
  logic                 v1;
  logic                 clr1;
  logic [WIDTH-1:0]     a1;
  logic [WIDTH-1:0]     b1;
  logic                 cin1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      clr1 <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      cin1 <= 1'b0;
    end else begin
      v1   <= in_valid;
      clr1 <= clear;
      a1   <= in_valid ? a : '0;
      b1   <= in_valid ? b : '0;
      cin1 <= in_valid & cin;
    end
  end

  // Stage 2: full-width product, zero-extended to the accumulator width.
  logic                 v2;
  logic                 clr2;
  logic [ACC_WIDTH-1:0] prod2;
  logic                 cin2;
  logic [PW-1:0]        prod_full;

  assign prod_full = PW'(a1) * PW'(b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2    <= 1'b0;
      clr2  <= 1'b0;
      prod2 <= '0;
      cin2  <= 1'b0;
    end else begin
      v2    <= v1;
      clr2  <= clr1;
      prod2 <= ACC_WIDTH'(prod_full);
      cin2  <= cin1;
    end
  end

  // Stage 3: accumulator and frame FSM.
  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 cout_q, cout_d;
  logic                 ov_q;

  logic [SW-1:0]        sum;
  logic [ACC_WIDTH-1:0] start_acc;
  logic [LEN_WIDTH-1:0] cnt_inc;
  logic                 start;

  // A fresh frame's first term, (2^W-1)^2 + 1, always fits in ACC_WIDTH.
  assign sum       = SW'(acc_q) + SW'(prod2) + SW'(cin2);
  assign start_acc = prod2 + ACC_WIDTH'(cin2);
  assign cnt_inc   = cnt_q + LEN_WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      cout_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      cout_q  <= cout_d;
      ov_q    <= (state_d == DONE);
    end
  end

  // Next-state: clear outranks frame completion; a valid sample arriving
  // in IDLE or DONE (or with clear) opens a new frame in the same cycle.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    cout_d  = cout_q;
    start   = 1'b0;

    if (clr2) begin
      if (v2) begin
        start = 1'b1;
      end else begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        cout_d  = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (v2) start = 1'b1;
        end
        ACC: begin
          if (v2) begin
            cnt_d = cnt_inc;
            if (sum[ACC_WIDTH]) begin
              cout_d = 1'b1;
              acc_d  = (SATURATE != 0) ? '1 : sum[ACC_WIDTH-1:0];
            end else if ((SATURATE != 0) && cout_q) begin
              // Saturated frames stay pinned at full scale.
              acc_d = '1;
            end else begin
              acc_d = sum[ACC_WIDTH-1:0];
            end
            if ((len_q != '0) && (cnt_inc == len_q)) state_d = DONE;
          end
        end
        DONE: begin
          if (v2) begin
            start = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            cout_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (start) begin
      acc_d   = start_acc;
      cnt_d   = LEN_WIDTH'(1);
      cout_d  = 1'b0;
      len_d   = acc_len;
      state_d = (acc_len == LEN_WIDTH'(1)) ? DONE : ACC;
    end
  end

  assign result    = acc_q;
  assign count     = cnt_q;
  assign cout      = cout_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Directed bench for mac_acc_pipe: one wrapping and one saturating instance
// share the same stimulus; expected values are hand-computed constants.
module tb_mac_acc_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       cin = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] acc_len = '0;

  logic [7:0] w_result, s_result;
  logic       w_ov, s_ov, w_cout, s_cout;
  logic [7:0] w_count, s_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_acc_pipe #(.WIDTH(4), .ACC_WIDTH(8), .SATURATE(0), .LEN_WIDTH(8)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .clear(clear), .acc_len(acc_len), .result(w_result), .out_valid(w_ov),
    .cout(w_cout), .count(w_count)
  );

  mac_acc_pipe #(.WIDTH(4), .ACC_WIDTH(8), .SATURATE(1), .LEN_WIDTH(8)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .clear(clear), .acc_len(acc_len), .result(s_result), .out_valid(s_ov),
    .cout(s_cout), .count(s_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] aa, input logic [3:0] bb,
                       input logic c, input logic clr);
    in_valid = v;
    a        = aa;
    b        = bb;
    cin      = c;
    clear    = clr;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] f_res [7];
    logic [7:0] f_cnt [7];
    logic       f_ov  [7];
    f_res = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd3};
    f_cnt = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd0};
    f_ov  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    idle();
    repeat (2) tick();
    check("rst_result_w", 32'(w_result), 32'd0);
    check("rst_count_w", 32'(w_count), 32'd0);
    check("rst_cout_w", 32'(w_cout), 32'd0);
    check("rst_ov_w", 32'(w_ov), 32'd0);
    check("rst_result_s", 32'(s_result), 32'd0);
    rst = 1'b1;
    tick();

    // Free-running accumulation, latency of two edges
    drive(1'b1, 4'd3, 4'd2, 1'b0, 1'b0); tick();
    drive(1'b1, 4'd5, 4'd1, 1'b0, 1'b0); tick();
    drive(1'b1, 4'd2, 4'd3, 1'b0, 1'b0); tick();
    check("acc_6", 32'(w_result), 32'd6);
    drive(1'b1, 4'd3, 4'd3, 1'b1, 1'b0); tick();
    check("acc_11", 32'(w_result), 32'd11);
    idle(); tick();
    check("acc_17", 32'(w_result), 32'd17);
    tick();
    check("acc_27_w", 32'(w_result), 32'd27);
    check("acc_27_s", 32'(s_result), 32'd27);
    check("acc_count", 32'(w_count), 32'd4);
    check("acc_cout", 32'(w_cout), 32'd0);
    check("acc_no_ov", 32'(w_ov), 32'd0);

    // Reset with a sample sitting in S2
    drive(1'b1, 4'd1, 4'd1, 1'b0, 1'b0); tick();
    idle(); tick();
    #2 rst = 1'b0;
    #1;
    check("async_rst_result", 32'(w_result), 32'd0);
    check("async_rst_count", 32'(w_count), 32'd0);
    check("async_rst_cout", 32'(w_cout), 32'd0);
    tick();
    rst = 1'b1;
    tick(); tick();
    check("flushed_result", 32'(w_result), 32'd0);
    drive(1'b1, 4'd15, 4'd15, 1'b0, 1'b0); tick();
    idle(); tick(); tick();
    check("post_rst_225_w", 32'(w_result), 32'd225);
    check("post_rst_225_s", 32'(s_result), 32'd225);
    check("post_rst_count", 32'(w_count), 32'd1);

    // Overflow: wrap vs saturate
    drive(1'b1, 4'd10, 4'd6, 1'b0, 1'b0); tick();
    idle(); tick(); tick();
    check("wrap_29", 32'(w_result), 32'd29);
    check("wrap_cout", 32'(w_cout), 32'd1);
    check("sat_255", 32'(s_result), 32'd255);
    check("sat_cout", 32'(s_cout), 32'd1);
    drive(1'b1, 4'd1, 4'd1, 1'b0, 1'b0); tick();
    idle(); tick(); tick();
    check("wrap_30", 32'(w_result), 32'd30);
    check("wrap_cout_sticky", 32'(w_cout), 32'd1);
    check("sat_hold_255", 32'(s_result), 32'd255);

    // Clear alone
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1); tick();
    idle(); tick(); tick();
    check("clr_result_w", 32'(w_result), 32'd0);
    check("clr_result_s", 32'(s_result), 32'd0);
    check("clr_cout_w", 32'(w_cout), 32'd0);
    check("clr_cout_s", 32'(s_cout), 32'd0);
    check("clr_count", 32'(w_count), 32'd0);
    check("clr_no_ov", 32'(w_ov), 32'd0);

    // Frames of three, back-to-back
    acc_len = 8'd3;
    for (int i = 0; i < 9; i++) begin
      if (i < 6) drive(1'b1, 4'd1, 4'd1, 1'b0, 1'b0);
      else idle();
      tick();
      if (i >= 2) begin
        check($sformatf("frm_result_%0d", i), 32'(w_result), 32'(f_res[i-2]));
        check($sformatf("frm_count_%0d", i), 32'(w_count), 32'(f_cnt[i-2]));
        check($sformatf("frm_ov_%0d", i), 32'(w_ov), 32'(f_ov[i-2]));
      end
    end

    // Clear with a valid sample mid-frame
    acc_len = 8'd0;
    drive(1'b1, 4'd4, 4'd4, 1'b0, 1'b0); tick();
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0); tick();
    drive(1'b1, 4'd2, 4'd2, 1'b0, 1'b1); tick();
    check("mid_16", 32'(w_result), 32'd16);
    idle(); tick();
    check("mid_17", 32'(w_result), 32'd17);
    tick();
    check("clr_smp_result", 32'(w_result), 32'd4);
    check("clr_smp_count", 32'(w_count), 32'd1);
    check("clr_smp_ov", 32'(w_ov), 32'd0);
    tick();
    check("clr_smp_hold", 32'(w_result), 32'd4);
    check("clr_smp_ov2", 32'(w_ov), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_acc_pipe.md
Name: mac_acc_pipe

Overview:
- Parametrised, pipelined multiply-accumulate unit; next generation of the 4-bit Vedic/Kogge-Stone MAC.
- Generalised in operand and accumulator width.
- Adds a valid-qualified input, a synchronous clear, frame-length accumulation with a result-valid pulse, and a wrap or saturate overflow mode with a sticky overflow flag.
- Sits between the operand source (sample/coefficient stream) and downstream result capture logic.

Parameters:
- WIDTH, 4, operand width of a and b (unsigned).
- ACC_WIDTH, 8, accumulator/result width. Legal range 2*WIDTH <= ACC_WIDTH <= 32.
- SATURATE, 0, overflow mode. 0 = wrap modulo 2^ACC_WIDTH; 1 = clamp to all-ones.
- LEN_WIDTH, 8, width of the frame-length input and the sample counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset. Asserting it clears all state immediately; deassertion is taken synchronously to clk.
- in_valid  in  1  a, b and cin are valid this cycle.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- cin  in  1  carry-in added to the accumulation together with a*b. Only used when in_valid=1.
- clear  in  1  synchronous accumulator clear. Travels down the pipeline with its cycle.
- acc_len  in  LEN_WIDTH  samples per frame. 0 = free-running (no frame end). Sampled when a frame starts.
- result  out  ACC_WIDTH  current accumulator value.
- out_valid  out  1  one-cycle pulse; result holds the completed frame total.
- cout  out  1  sticky overflow flag for the current frame.
- count  out  LEN_WIDTH  number of samples accumulated in the current frame.

Behaviour:
- Reset (rst=0): result=0, out_valid=0, cout=0, count=0, all pipeline valid bits=0, FSM=IDLE.
- Reset mid-frame discards all in-flight samples.
- Pipeline: S1 registers a, b, cin, in_valid, clear. S2 registers product = a*b (2*WIDTH bits, zero-extended to ACC_WIDTH). S3 updates the accumulator.
- Latency: a sample presented before edge k is reflected in result after edge k+2. Throughput is 1 sample/cycle; no backpressure.
- Accumulate: sum = acc + product + cin, computed at ACC_WIDTH+1 bits.
  - Bit ACC_WIDTH set → overflow.
  - SATURATE=0: acc takes the low ACC_WIDTH bits.
  - SATURATE=1: acc = 2^ACC_WIDTH-1. Once saturated it stays saturated for the rest of the frame.
  - Overflow sets cout; cout remains 1 until the frame restarts or is cleared.
- FSM states:
  - IDLE: count=0. A valid S3 sample moves to ACC; acc = product+cin; acc_len is latched into len_q.
  - ACC: each valid S3 sample accumulates and count increments. If len_q != 0 and count+1 == len_q → DONE.
  - DONE: lasts exactly one cycle. out_valid=1; result holds the final total. Next state is IDLE (count→0, cout→0; result keeps the final value until the next sample lands).
- A valid sample reaching S3 while in DONE starts a new frame in the same cycle (acc = product+cin, count=1, latch acc_len). No sample is dropped.
- acc_len=1: every sample produces out_valid two edges later (ACC→DONE back-to-back). len_q=0: never enters DONE; count wraps modulo 2^LEN_WIDTH without side effects.
- Clear at S3:
  - Without a valid sample: acc=0, count=0, cout=0, FSM→IDLE, no out_valid.
  - With a valid sample: the frame restarts with that sample (acc = product+cin, count=1). Clear takes priority over DONE.
- in_valid=0 cycles (bubbles) leave acc, count and cout unchanged.
- No X propagation: a, b and cin are ignored when in_valid=0.

Test Plan:
- Defaults, acc_len=0. Samples (3,2,0), (5,1,0), (2,3,0), (3,3,1) on consecutive cycles → result 6, 11, 17, 27 on edges k+2..k+5; cout=0; count=4.
- rst pulled low mid-stream with a sample in S2 → result=0, count=0, cout=0 immediately. After release, the next sample (15,15,0) → result=225.
- SATURATE=0: (15,15,0) then (10,6,0) → result 225, then 29 (285 mod 256), cout=1. clear alone → result 0, cout 0.
- SATURATE=1: same stimulus → 225, then 255, cout=1. A further (1,1,0) keeps result at 255.
- acc_len=3, six back-to-back samples (1,1,0) → out_valid pulses after the 3rd and 6th samples with result=3. The 4th sample starts the new frame with result=1 and count=1, no gap.
- clear asserted together with a valid sample (2,2,0) mid-frame (result=17) → result=4, count=1, no out_valid pulse.
